irom_arb: RTL
=============

IROM_ARB -- requirements
Module: irom_arb

Interface
REQ-001 Parameters SHALL be:
- FIXED_PRIO, 0, 0 = round-robin between ports, 1 = port A always wins.
- ROM_ABITS, 14, number of word-address bits the ROM decodes.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock; all state on posedge.
- RST, in, 1, reset, asynchronous and active-high.
- A_REQ, in, 1, port A read request.
- A_ADDR, in, 24, port A word address.
- A_ACK, out, 1, port A request accepted this cycle.
- A_RVALID, out, 1, port A read data/error valid.
- A_RDATA, out, 32, port A read data.
- A_RERR, out, 1, port A address-range error.
- B_REQ, B_ADDR, B_ACK, B_RVALID, B_RDATA, B_RERR: identical to port A, for port B.
- ROM_CS, out, 1, ROM read strobe.
- ROM_ADDR, out, 24, ROM word address.
- ROM_DOUT, in, 32, ROM data, registered inside the ROM, valid the cycle after ROM_CS.

Function
REQ-003 Requests SHALL be level-held: a requester SHALL keep REQ and ADDR stable until it sees ACK high at a posedge; the arbiter SHALL never drop a held request.
REQ-004 At most one of A_ACK/B_ACK SHALL be high per cycle; ACK SHALL be combinational from REQ, the address-range check and the priority state.
REQ-005 Only one port requesting: that port SHALL be granted.
REQ-006 Both ports requesting, FIXED_PRIO=0: the port not granted last SHALL win, so alternation yields one grant per port every two cycles.
REQ-007 Both ports requesting, FIXED_PRIO=1: A SHALL win every cycle (B may starve, by design).
REQ-008 last_grant SHALL update only on a cycle with a grant; idle cycles SHALL leave it unchanged.
REQ-009 Range check: the grant is in range if ADDR[23:ROM_ABITS] == 0.
REQ-010 In-range grant: ROM_CS SHALL be 1 and ROM_ADDR SHALL be the winner's ADDR in the same cycle.
REQ-011 Out-of-range grant: ACK SHALL still be issued, but ROM_CS SHALL be 0 and ROM_ADDR SHALL be 0.
REQ-012 No grant: ROM_CS SHALL be 0 and ROM_ADDR SHALL be 0.
REQ-013 Registered owner state (1-bit valid, 1-bit port id, 1-bit error) SHALL record each grant.
REQ-014 The owner's RVALID SHALL assert exactly one cycle after its ACK (latency 1), for exactly one cycle per ACK.
REQ-015 Throughput SHALL be one grant per cycle, with back-to-back grants to the same or different ports.
REQ-016 Owner's RDATA when RVALID=1 and error=0: RDATA SHALL be ROM_DOUT and RERR SHALL be 0.
REQ-017 Owner's RDATA when RVALID=1 and error=1: RDATA SHALL be 32'h0 and RERR SHALL be 1.
REQ-018 When a port's RVALID=0, its RDATA SHALL hold the last value delivered to that port (per-port 32-bit hold register) and its RERR SHALL be 0.
REQ-019 The non-owner port SHALL see RVALID=0 and its own held RDATA.
REQ-020 Cycles where ROM_CS=0 SHALL NOT alter delivered data; the ROM is relied on to hold its output when CS=0.

Reset
REQ-021 While RST=1, all outputs SHALL be 0: ACKs, RVALIDs, RERRs, RDATAs, ROM_CS, ROM_ADDR.
REQ-022 RST SHALL clear the owner state and hold registers, and SHALL set last_grant=B so that A wins the first conflict.
REQ-023 A grant issued in the cycle RST asserts SHALL produce no RVALID; requesters SHALL re-request after RST deasserts.
REQ-024 The first grant SHALL be possible in the first cycle with RST=0.

Verification
REQ-025 Single port: A_REQ=1, A_ADDR=0x000010, ROM[0x10]=0xDEADBEEF -> A_ACK=1 and ROM_CS=1 in cycle N; A_RVALID=1 with A_RDATA=0xDEADBEEF in N+1; B_RVALID=0 throughout.
REQ-026 Conflict, round-robin: A and B both held requesting from reset (A_ADDR=1, B_ADDR=2) -> grants A,B,A,B in consecutive cycles; RVALIDs alternate one cycle later with ROM[1] and ROM[2].
REQ-027 Conflict, FIXED_PRIO=1: both request for 4 cycles -> A_ACK=1 in all 4 cycles and B_ACK=0; B is granted in the first cycle A_REQ drops.
REQ-028 Range error: B_ADDR=0x004000 with ROM_ABITS=14 -> B_ACK=1 and ROM_CS=0 in cycle N; B_RVALID=1, B_RERR=1 and B_RDATA=0 in N+1; the next in-range read returns correct data.
REQ-029 Hold: A reads 0x11111111, then idles 3 cycles while B reads 0x22222222 -> A_RDATA stays 0x11111111 and B_RDATA stays 0x22222222 after their respective RVALIDs.
REQ-030 Reset mid-operation: RST asserted in the same cycle as A_ACK -> no A_RVALID follows, all outputs are 0; after release, a simultaneous A/B request grants A first.

Source files
------------

// File: rtl/irom_arb.sv
// Two-port instruction-ROM read arbiter.
//
// Purpose: shares one registered-output ROM between read ports A and B. A grant (ACK) is
// combinational from the requests, the address-range check and the priority state. The ROM
// data comes back one cycle later and goes to the port that owned the grant. Each port keeps
// a hold register so its RDATA stays at the last delivered word while RVALID is low.
//
// Ports:
//   CLK, RST                     clock; asynchronous active-high reset
//   A_REQ, A_ADDR                port A level-held request and word address
//   A_ACK                        port A request accepted this cycle
//   A_RVALID, A_RDATA, A_RERR    port A read return (data, or range error)
//   B_*                          identical to port A, for port B
//   ROM_CS, ROM_ADDR             ROM read strobe and word address
//   ROM_DOUT                     ROM data, valid the cycle after ROM_CS
module irom_arb #(
    parameter bit          FIXED_PRIO = 1'b0,  // 1: port A always wins a conflict
    parameter int unsigned ROM_ABITS  = 14     // word-address bits the ROM decodes
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_REQ,
    input  logic [23:0] A_ADDR,
    output logic        A_ACK,
    output logic        A_RVALID,
    output logic [31:0] A_RDATA,
    output logic        A_RERR,
    input  logic        B_REQ,
    input  logic [23:0] B_ADDR,
    output logic        B_ACK,
    output logic        B_RVALID,
    output logic [31:0] B_RDATA,
    output logic        B_RERR,
    output logic        ROM_CS,
    output logic [23:0] ROM_ADDR,
    input  logic [31:0] ROM_DOUT
);

    typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

    port_e       last_q, last_d;
    logic        own_vld_q, own_vld_d;
    port_e       own_port_q, own_port_d;
    logic        own_err_q, own_err_d;
    logic [31:0] a_hold_q, a_hold_d;
    logic [31:0] b_hold_q, b_hold_d;

    logic        a_in_range, b_in_range;
    logic        a_pri, a_win, b_win, grant, win_in_range;
    logic [23:0] win_addr;
    logic        a_rvalid, b_rvalid;
    logic [31:0] deliver_data;

    // Grant and ROM strobe.
    always_comb begin
        a_in_range   = (A_ADDR[23:ROM_ABITS] == '0);
        b_in_range   = (B_ADDR[23:ROM_ABITS] == '0);
        // A wins when alone, under fixed priority, or when B was granted last.
        a_pri        = A_REQ && (!B_REQ || FIXED_PRIO || (last_q == PortB));
        // Gating with RST keeps every output low while reset is held.
        a_win        = !RST && a_pri;
        b_win        = !RST && B_REQ && !a_pri;
        grant        = a_win || b_win;
        win_addr     = a_win ? A_ADDR : B_ADDR;
        win_in_range = a_win ? a_in_range : b_in_range;

        A_ACK    = a_win;
        B_ACK    = b_win;
        ROM_CS   = grant && win_in_range;
        ROM_ADDR = (grant && win_in_range) ? win_addr : '0;

        last_d     = grant ? (b_win ? PortB : PortA) : last_q;
        own_vld_d  = grant;
        own_port_d = b_win ? PortB : PortA;
        own_err_d  = !win_in_range;
    end

    // Read return to the owner of last cycle's grant; the other port shows its held word.
    always_comb begin
        a_rvalid     = own_vld_q && (own_port_q == PortA);
        b_rvalid     = own_vld_q && (own_port_q == PortB);
        deliver_data = own_err_q ? 32'h0 : ROM_DOUT;

        A_RVALID = a_rvalid;
        B_RVALID = b_rvalid;
        A_RDATA  = a_rvalid ? deliver_data : a_hold_q;
        B_RDATA  = b_rvalid ? deliver_data : b_hold_q;
        A_RERR   = a_rvalid && own_err_q;
        B_RERR   = b_rvalid && own_err_q;

        a_hold_d = a_rvalid ? deliver_data : a_hold_q;
        b_hold_d = b_rvalid ? deliver_data : b_hold_q;
    end

    // Reset leaves last_grant at B so A wins the first conflict.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q     <= PortB;
            own_vld_q  <= 1'b0;
            own_port_q <= PortA;
            own_err_q  <= 1'b0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            last_q     <= last_d;
            own_vld_q  <= own_vld_d;
            own_port_q <= own_port_d;
            own_err_q  <= own_err_d;
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
        end
    end

endmodule
